// File: rtl/ym3438_timer.sv
// YM3438 Timer A/B block: decodes register writes 0x24-0x27 and runs the two
// reloading up-counters, their status flags, the CSM overflow pulse and CH3 mode.
module ym3438_timer #(
    parameter int TB_PRESCALE_BITS = 4
) (
    input  logic       MCLK,
    input  logic       reset,
    input  logic       timer_tick,
    input  logic       write_addr_en,
    input  logic       write_data_en,
    input  logic [7:0] data_bus,
    input  logic       bank,
    output logic       timer_a,
    output logic       timer_b,
    output logic       timer_a_ovf,
    output logic [1:0] ch3_mode
);

    localparam logic [TB_PRESCALE_BITS-1:0] PRESC_ONE = 1;

    logic [8:0]                  addr_reg;
    logic [9:0]                  ta_reg;
    logic [7:0]                  tb_reg;
    logic                        load_a_reg;
    logic                        load_b_reg;
    logic                        en_a_reg;
    logic                        en_b_reg;
    logic [1:0]                  ch3_reg;
    logic [9:0]                  cnt_a_reg;
    logic [7:0]                  cnt_b_reg;
    logic [TB_PRESCALE_BITS-1:0] presc_reg;
    logic                        flag_a_reg;
    logic                        flag_b_reg;
    logic                        ovf_a_reg;

    logic wr_24;
    logic wr_25;
    logic wr_26;
    logic wr_27;
    logic load_a_rise;
    logic load_b_rise;
    logic presc_wrap;
    logic ovf_a;
    logic ovf_b;

    // Data strobes always decode the address stored before this edge.
    always_comb begin
        wr_24       = write_data_en && !addr_reg[8] && (addr_reg[7:0] == 8'h24);
        wr_25       = write_data_en && !addr_reg[8] && (addr_reg[7:0] == 8'h25);
        wr_26       = write_data_en && !addr_reg[8] && (addr_reg[7:0] == 8'h26);
        wr_27       = write_data_en && !addr_reg[8] && (addr_reg[7:0] == 8'h27);
        load_a_rise = wr_27 && data_bus[0] && !load_a_reg;
        load_b_rise = wr_27 && data_bus[1] && !load_b_reg;
        presc_wrap  = timer_tick && (presc_reg == '1);
        ovf_a       = load_a_reg && timer_tick && (cnt_a_reg == 10'h3FF);
        ovf_b       = load_b_reg && presc_wrap && (cnt_b_reg == 8'hFF);
    end

    always_ff @(posedge MCLK) begin
        if (reset) begin
            addr_reg   <= '0;
            ta_reg     <= '0;
            tb_reg     <= '0;
            load_a_reg <= 1'b0;
            load_b_reg <= 1'b0;
            en_a_reg   <= 1'b0;
            en_b_reg   <= 1'b0;
            ch3_reg    <= '0;
        end else begin
            if (write_addr_en) begin
                addr_reg <= {bank, data_bus};
            end
            if (wr_24) begin
                ta_reg[9:2] <= data_bus;
            end
            if (wr_25) begin
                ta_reg[1:0] <= data_bus[1:0];
            end
            if (wr_26) begin
                tb_reg <= data_bus;
            end
            if (wr_27) begin
                load_a_reg <= data_bus[0];
                load_b_reg <= data_bus[1];
                en_a_reg   <= data_bus[2];
                en_b_reg   <= data_bus[3];
                ch3_reg    <= data_bus[7:6];
            end
        end
    end

    // A fresh load swallows a coincident tick; otherwise count and reload at terminal.
    always_ff @(posedge MCLK) begin
        if (reset) begin
            cnt_a_reg <= '0;
            cnt_b_reg <= '0;
            presc_reg <= '0;
        end else begin
            if (timer_tick) begin
                presc_reg <= presc_reg + PRESC_ONE;
            end
            if (load_a_rise) begin
                cnt_a_reg <= ta_reg;
            end else if (load_a_reg && timer_tick) begin
                cnt_a_reg <= ovf_a ? ta_reg : cnt_a_reg + 10'd1;
            end
            if (load_b_rise) begin
                cnt_b_reg <= tb_reg;
            end else if (load_b_reg && presc_wrap) begin
                cnt_b_reg <= ovf_b ? tb_reg : cnt_b_reg + 8'd1;
            end
        end
    end

    // Flag set takes priority over a same-cycle clear so no overflow is lost.
    always_ff @(posedge MCLK) begin
        if (reset) begin
            flag_a_reg <= 1'b0;
            flag_b_reg <= 1'b0;
            ovf_a_reg  <= 1'b0;
        end else begin
            ovf_a_reg <= ovf_a;
            if (ovf_a && en_a_reg) begin
                flag_a_reg <= 1'b1;
            end else if (wr_27 && data_bus[4]) begin
                flag_a_reg <= 1'b0;
            end
            if (ovf_b && en_b_reg) begin
                flag_b_reg <= 1'b1;
            end else if (wr_27 && data_bus[5]) begin
                flag_b_reg <= 1'b0;
            end
        end
    end

    assign timer_a     = flag_a_reg;
    assign timer_b     = flag_b_reg;
    assign timer_a_ovf = ovf_a_reg;
    assign ch3_mode    = ch3_reg;

endmodule

// File: tb/tb_ym3438_timer.sv
// Self-checking bench for ym3438_timer: directed scenarios plus random traffic
// compared against a ticks-remaining model of the two timers.
module tb_ym3438_timer;

    logic       MCLK = 1'b0;
    logic       reset = 1'b1;
    logic       timer_tick = 1'b0;
    logic       write_addr_en = 1'b0;
    logic       write_data_en = 1'b0;
    logic [7:0] data_bus = 8'h00;
    logic       bank = 1'b0;
    logic       timer_a;
    logic       timer_b;
    logic       timer_a_ovf;
    logic [1:0] ch3_mode;

    int checks_total = 0;
    int checks_passed = 0;

    // Model state: counters are kept as "ticks left until overflow".
    logic [8:0] m_addr;
    logic [9:0] m_ta;
    logic [7:0] m_tb;
    bit         m_load_a, m_load_b, m_en_a, m_en_b;
    logic [1:0] m_ch3;
    bit         m_flag_a, m_flag_b, m_ovf;
    int         a_left, b_left, presc_ticks;

    ym3438_timer #(.TB_PRESCALE_BITS(4)) dut (
        .MCLK(MCLK),
        .reset(reset),
        .timer_tick(timer_tick),
        .write_addr_en(write_addr_en),
        .write_data_en(write_data_en),
        .data_bus(data_bus),
        .bank(bank),
        .timer_a(timer_a),
        .timer_b(timer_b),
        .timer_a_ovf(timer_a_ovf),
        .ch3_mode(ch3_mode)
    );

    always #5 MCLK = ~MCLK;

    function automatic logic [4:0] model_out();
        return {m_flag_a, m_flag_b, m_ovf, m_ch3};
    endfunction

    task automatic model_reset();
        m_addr = '0; m_ta = '0; m_tb = '0;
        m_load_a = 0; m_load_b = 0; m_en_a = 0; m_en_b = 0; m_ch3 = '0;
        m_flag_a = 0; m_flag_b = 0; m_ovf = 0;
        a_left = 1024; b_left = 256; presc_ticks = 0;
    endtask

    task automatic model_step(input bit r, input bit t, input bit ae, input bit de,
                              input logic [7:0] d, input bit bk);
        bit w24, w25, w26, w27, ova, ovb, wrap;
        int na, nb;
        if (r) begin
            model_reset();
            return;
        end
        w24  = de && (m_addr == 9'h024);
        w25  = de && (m_addr == 9'h025);
        w26  = de && (m_addr == 9'h026);
        w27  = de && (m_addr == 9'h027);
        wrap = t && (presc_ticks == 15);
        ova  = m_load_a && t && (a_left == 1);
        ovb  = m_load_b && wrap && (b_left == 1);
        na = a_left;
        nb = b_left;
        if (w27 && d[0] && !m_load_a) na = 1024 - int'(m_ta);
        else if (m_load_a && t) na = ova ? 1024 - int'(m_ta) : a_left - 1;
        if (w27 && d[1] && !m_load_b) nb = 256 - int'(m_tb);
        else if (m_load_b && wrap) nb = ovb ? 256 - int'(m_tb) : b_left - 1;
        if (ova && m_en_a) m_flag_a = 1;
        else if (w27 && d[4]) m_flag_a = 0;
        if (ovb && m_en_b) m_flag_b = 1;
        else if (w27 && d[5]) m_flag_b = 0;
        m_ovf = ova;
        if (w24) m_ta[9:2] = d;
        if (w25) m_ta[1:0] = d[1:0];
        if (w26) m_tb = d;
        if (w27) begin
            m_load_a = d[0]; m_load_b = d[1]; m_en_a = d[2]; m_en_b = d[3]; m_ch3 = d[7:6];
        end
        if (ae) m_addr = {bk, d};
        if (t) presc_ticks = (presc_ticks + 1) % 16;
        a_left = na;
        b_left = nb;
    endtask

    task automatic cycle(input bit t, input bit ae, input bit de,
                         input logic [7:0] d, input bit bk);
        timer_tick = t; write_addr_en = ae; write_data_en = de; data_bus = d; bank = bk;
        @(posedge MCLK);
        model_step(reset, t, ae, de, d, bk);
        #1;
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
        cycle(0, 1, 0, a, 0);
        cycle(0, 0, 1, d, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle(0, 0, 0, 8'h00, 0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle(1, 1, 1, 8'hFF, 1);
        cycle(0, 0, 0, 8'h00, 0);
        checks_total++;
        if ({timer_a, timer_b, timer_a_ovf, ch3_mode} !== 5'b0)
            $display("FAIL reset_outputs got=%b want=%b", {timer_a, timer_b, timer_a_ovf, ch3_mode}, 5'b0);
        else checks_passed++;
        reset = 1'b0;
    endtask

    task automatic test_timer_a_period();
        do_reset();
        wr_reg(8'h24, 8'hFF);
        wr_reg(8'h25, 8'h00);
        wr_reg(8'h27, 8'h05);
        for (int i = 1; i <= 12; i++) begin
            cycle(1, 0, 0, 8'h00, 0);
            checks_total++;
            if (timer_a_ovf !== ((i % 4) == 0) || timer_a !== (i >= 4))
                $display("FAIL a_period tick=%0d got ovf=%b flag=%b want ovf=%b flag=%b",
                         i, timer_a_ovf, timer_a, (i % 4) == 0, i >= 4);
            else checks_passed++;
            cycle(0, 0, 0, 8'h00, 0);
            checks_total++;
            if (timer_a_ovf !== 1'b0 || {timer_a, timer_b, timer_a_ovf, ch3_mode} !== model_out())
                $display("FAIL a_ovf_width tick=%0d got=%b want=%b",
                         i, {timer_a, timer_b, timer_a_ovf, ch3_mode}, model_out());
            else checks_passed++;
        end
    endtask

    task automatic test_min_period_clear();
        wr_reg(8'h25, 8'h03);
        wr_reg(8'h27, 8'h04);
        wr_reg(8'h27, 8'h05);
        for (int i = 1; i <= 4; i++) begin
            cycle(1, 0, 0, 8'h00, 0);
            checks_total++;
            if (timer_a_ovf !== 1'b1 || {timer_a, timer_b, timer_a_ovf, ch3_mode} !== model_out())
                $display("FAIL min_period tick=%0d got=%b want=%b",
                         i, {timer_a, timer_b, timer_a_ovf, ch3_mode}, model_out());
            else checks_passed++;
        end
        wr_reg(8'h27, 8'h15);
        checks_total++;
        if (timer_a !== 1'b0)
            $display("FAIL a_clear got=%b want=0", timer_a);
        else checks_passed++;
        cycle(1, 0, 0, 8'h00, 0);
        checks_total++;
        if (timer_a !== 1'b1 || timer_a_ovf !== 1'b1)
            $display("FAIL a_reset_after_clear got flag=%b ovf=%b want 1 1", timer_a, timer_a_ovf);
        else checks_passed++;
    endtask

    task automatic test_timer_b();
        int n;
        do_reset();
        wr_reg(8'h26, 8'hFF);
        wr_reg(8'h27, 8'h0A);
        for (int i = 1; i <= 16; i++) begin
            cycle(1, 0, 0, 8'h00, 0);
            checks_total++;
            if (timer_b !== (i >= 16) || {timer_a, timer_b, timer_a_ovf, ch3_mode} !== model_out())
                $display("FAIL b_first_period tick=%0d got=%b want_b=%b", i, timer_b, i >= 16);
            else checks_passed++;
        end
        wr_reg(8'h26, 8'hFE);
        for (int pass = 0; pass < 2; pass++) begin
            wr_reg(8'h27, 8'h2A);
            checks_total++;
            if (timer_b !== 1'b0)
                $display("FAIL b_clear pass=%0d got=%b want=0", pass, timer_b);
            else checks_passed++;
            n = 0;
            while (n < 100 && timer_b !== 1'b1) begin
                cycle(1, 0, 0, 8'h00, 0);
                n++;
            end
            checks_total++;
            if (n != (pass == 0 ? 16 : 32))
                $display("FAIL b_period pass=%0d got=%0d ticks want=%0d", pass, n, pass == 0 ? 16 : 32);
            else checks_passed++;
        end
    endtask

    task automatic test_enable_gating();
        do_reset();
        wr_reg(8'h24, 8'hFF);
        wr_reg(8'h25, 8'h03);
        wr_reg(8'h27, 8'h01);
        cycle(1, 0, 0, 8'h00, 0);
        checks_total++;
        if (timer_a_ovf !== 1'b1 || timer_a !== 1'b0)
            $display("FAIL gate_ovf got ovf=%b flag=%b want 1 0", timer_a_ovf, timer_a);
        else checks_passed++;
        wr_reg(8'h27, 8'h40);
        checks_total++;
        if (ch3_mode !== 2'b01)
            $display("FAIL ch3_mode got=%b want=01", ch3_mode);
        else checks_passed++;
        for (int i = 0; i < 5; i++) begin
            cycle(1, 0, 0, 8'h00, 0);
            checks_total++;
            if (timer_a_ovf !== 1'b0 || {timer_a, timer_b, timer_a_ovf, ch3_mode} !== model_out())
                $display("FAIL gate_hold tick=%0d got=%b want=%b",
                         i, {timer_a, timer_b, timer_a_ovf, ch3_mode}, model_out());
            else checks_passed++;
        end
    endtask

    task automatic test_filtering();
        do_reset();
        wr_reg(8'h24, 8'hFF);
        wr_reg(8'h25, 8'h03);
        wr_reg(8'h26, 8'hFF);
        cycle(0, 1, 0, 8'h27, 1);
        cycle(0, 0, 1, 8'h0F, 0);
        wr_reg(8'h28, 8'h0F);
        for (int i = 0; i < 20; i++) begin
            cycle(1, 0, 0, 8'h00, 0);
            checks_total++;
            if ({timer_a, timer_b, timer_a_ovf} !== 3'b000 ||
                {timer_a, timer_b, timer_a_ovf, ch3_mode} !== model_out())
                $display("FAIL filter tick=%0d got=%b want=%b",
                         i, {timer_a, timer_b, timer_a_ovf, ch3_mode}, model_out());
            else checks_passed++;
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        wr_reg(8'h24, 8'hFF);
        wr_reg(8'h25, 8'h03);
        wr_reg(8'h27, 8'h05);
        cycle(1, 0, 0, 8'h00, 0);
        cycle(1, 0, 1, 8'h15, 0);
        checks_total++;
        if (timer_a !== 1'b1 || timer_a_ovf !== 1'b1)
            $display("FAIL set_beats_clear got flag=%b ovf=%b want 1 1", timer_a, timer_a_ovf);
        else checks_passed++;
        cycle(0, 1, 1, 8'h15, 0);
        checks_total++;
        if (timer_a !== 1'b0 || {timer_a, timer_b, timer_a_ovf, ch3_mode} !== model_out())
            $display("FAIL both_strobes got flag=%b want=0", timer_a);
        else checks_passed++;
        wr_reg(8'h27, 8'h04);
        cycle(1, 0, 1, 8'h05, 0);
        checks_total++;
        if (timer_a_ovf !== 1'b0)
            $display("FAIL load_with_tick got ovf=%b want=0", timer_a_ovf);
        else checks_passed++;
        cycle(1, 0, 0, 8'h00, 0);
        checks_total++;
        if (timer_a_ovf !== 1'b1 || timer_a !== 1'b1)
            $display("FAIL after_load_tick got ovf=%b flag=%b want 1 1", timer_a_ovf, timer_a);
        else checks_passed++;
        wr_reg(8'h27, 8'hC5);
        reset = 1'b1;
        cycle(1, 0, 1, 8'hFF, 0);
        reset = 1'b0;
        checks_total++;
        if ({timer_a, timer_b, timer_a_ovf, ch3_mode} !== 5'b0)
            $display("FAIL reset_mid_count got=%b want=00000", {timer_a, timer_b, timer_a_ovf, ch3_mode});
        else checks_passed++;
    endtask

    task automatic test_random();
        bit t, ae, de, bk;
        logic [7:0] d;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 599) == 0);
            t  = $urandom_range(0, 1);
            ae = ($urandom_range(0, 3) == 0);
            de = ($urandom_range(0, 2) == 0);
            bk = 0;
            d  = 8'($urandom_range(0, 255));
            if (ae) begin
                d  = 8'h24 + 8'($urandom_range(0, 4));
                bk = ($urandom_range(0, 7) == 0);
            end else if (de && m_addr == 9'h024) begin
                d = 8'($urandom_range(8'hF0, 8'hFF));
            end else if (de && m_addr == 9'h026) begin
                d = 8'($urandom_range(8'hFA, 8'hFF));
            end
            cycle(t, ae, de, d, bk);
            checks_total++;
            if ({timer_a, timer_b, timer_a_ovf, ch3_mode} !== model_out())
                $display("FAIL random cyc=%0d got=%b want=%b",
                         i, {timer_a, timer_b, timer_a_ovf, ch3_mode}, model_out());
            else checks_passed++;
        end
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_timer_a_period();
        test_min_period_clear();
        test_timer_b();
        test_enable_gating();
        test_filtering();
        test_simultaneous();
        test_random();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
